// File: rtl/alu_op_sequencer_pkg.sv
// alu_op_sequencer_pkg: shared ALU op codes, opcode/funct constants, FSM states and the ALU-op decoder
package alu_op_sequencer_pkg;
  localparam logic [3:0] ALUADD  = 4'd0;
  localparam logic [3:0] ALUSUB  = 4'd1;
  localparam logic [3:0] ALUXOR  = 4'd2;
  localparam logic [3:0] ALUOR   = 4'd3;
  localparam logic [3:0] ALUAND  = 4'd4;
  localparam logic [3:0] ALUSLL  = 4'd5;
  localparam logic [3:0] ALUSRL  = 4'd6;
  localparam logic [3:0] ALUSRA  = 4'd7;
  localparam logic [3:0] ALUSLT  = 4'd8;
  localparam logic [3:0] ALUSLTU = 4'd9;
  localparam logic [6:0] RTYPE     = 7'b0110011;
  localparam logic [6:0] ITYPE_ALU = 7'b0010011;
  localparam logic [6:0] BRANCH    = 7'b1100011;
  localparam logic [6:0] MULDIV    = 7'b0000001;
  localparam logic [2:0] F3_ADDSUB = 3'b000;
  localparam logic [2:0] F3_SLL    = 3'b001;
  localparam logic [2:0] F3_SLT    = 3'b010;
  localparam logic [2:0] F3_SLTU   = 3'b011;
  localparam logic [2:0] F3_XOR    = 3'b100;
  localparam logic [2:0] F3_SR     = 3'b101;
  localparam logic [2:0] F3_OR     = 3'b110;
  localparam logic [2:0] F3_AND    = 3'b111;
  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;
  typedef enum logic [1:0] {MD_IDLE, MD_CALC, MD_DONE} md_state_e;
  function automatic logic [3:0] alu_f3(input logic [2:0] f3, input logic alt);
    case (f3)
      F3_ADDSUB: return alt ? ALUSUB : ALUADD;
      F3_SLL:    return ALUSLL;
      F3_SLT:    return ALUSLT;
      F3_SLTU:   return ALUSLTU;
      F3_XOR:    return ALUXOR;
      F3_SR:     return alt ? ALUSRA : ALUSRL;
      F3_OR:     return ALUOR;
      default:   return ALUAND;
    endcase
  endfunction
  // immediate ALU ops only honour bit30 for the right-shift pair
  function automatic logic [3:0] decode_aluop(input logic [31:0] i);
    case (i[6:0])
      RTYPE:     return alu_f3(i[14:12], i[30]);
      ITYPE_ALU: return alu_f3(i[14:12], i[30] && i[14:12] == F3_SR);
      BRANCH:    return i[14] ? (i[13] ? ALUSLTU : ALUSLT) : ALUSUB;
      default:   return ALUADD;
    endcase
  endfunction
endpackage

// File: rtl/alu_op_sequencer_if.sv
// alu_op_sequencer_if: decode-side handshake, operands, flush and ALU/muldiv results
// master = upstream/decode driver, slave = alu_op_sequencer
interface alu_op_sequencer_if #(parameter int IWIDTH = 32, parameter int XLEN = 32, parameter int AWIDTH = 4);
  logic in_valid, in_ready, flush, aluop_valid, md_valid, busy, illegal;
  logic [IWIDTH-1:0] instruction;
  logic [XLEN-1:0] rs1_data, rs2_data, md_result;
  logic [AWIDTH-1:0] aluop;
  modport master(output in_valid, instruction, rs1_data, rs2_data, flush,
                 input in_ready, aluop, aluop_valid, md_valid, md_result, busy, illegal);
  modport slave(input in_valid, instruction, rs1_data, rs2_data, flush,
                output in_ready, aluop, aluop_valid, md_valid, md_result, busy, illegal);
endinterface

// File: rtl/alu_op_sequencer_muldiv_iter.sv
// muldiv_iter: iterative RV32M engine (shift-add multiply, restoring divide) on operand magnitudes
// ports: start/f3/a/b launch an op, flush aborts, done pulses with result, busy while iterating
// only built when MULDIV_EN is defined
`ifdef MULDIV_EN
module muldiv_iter
  import alu_op_sequencer_pkg::*;
#(parameter int XLEN = 32) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            flush,
  input  logic [2:0]      f3,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            done,
  output logic            busy,
  output logic [XLEN-1:0] result
);
  localparam int CW = $clog2(XLEN);
  md_state_e state, state_n;
  logic [CW-1:0] cnt;
  logic [2:0] op;
  logic neg, a_neg, b_neg, div0, ovf, special;
  logic [XLEN-1:0] mb, div_sel, fin, spec_res;
  logic [XLEN:0] sum, shifted, diff;
  logic [2*XLEN-1:0] p, p_step, p_neg;
  always_comb begin
    a_neg = (f3 inside {F3_MULH, F3_MULHSU, F3_DIV, F3_REM}) && a[XLEN-1];
    b_neg = (f3 inside {F3_MULH, F3_DIV, F3_REM}) && b[XLEN-1];
    div0 = f3[2] && b == '0;
    ovf = f3[2] && !f3[0] && a == {1'b1, {(XLEN-1){1'b0}}} && b == '1;
    special = div0 || ovf;
    spec_res = div0 ? (f3[1] ? a : '1) : (f3[1] ? '0 : a);
    // p holds {accumulator/remainder, multiplier/dividend->quotient}
    sum = {1'b0, p[2*XLEN-1:XLEN]} + (p[0] ? {1'b0, mb} : '0);
    shifted = {p[2*XLEN-1:XLEN], p[XLEN-1]};
    diff = shifted - {1'b0, mb};
    p_step = op[2] ? (diff[XLEN] ? {shifted[XLEN-1:0], p[XLEN-2:0], 1'b0} : {diff[XLEN-1:0], p[XLEN-2:0], 1'b1})
                   : {sum, p[XLEN-1:1]};
    p_neg = neg ? -p_step : p_step;
    div_sel = op[1] ? p_step[2*XLEN-1:XLEN] : p_step[XLEN-1:0];
    fin = op[2] ? (neg ? -div_sel : div_sel) : (op == F3_MUL ? p_neg[XLEN-1:0] : p_neg[2*XLEN-1:XLEN]);
    state_n = flush ? MD_IDLE : start ? (special ? MD_DONE : MD_CALC)
            : state == MD_CALC ? (cnt == '0 ? MD_DONE : MD_CALC) : MD_IDLE;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= MD_IDLE;
      cnt <= '0;
      op <= '0;
      neg <= 1'b0;
      mb <= '0;
      p <= '0;
      result <= '0;
    end else begin
      state <= state_n;
      if (start) begin
        op <= f3;
        neg <= f3[2] && f3[1] ? a_neg : a_neg ^ b_neg;
        mb <= b_neg ? -b : b;
        p <= {{XLEN{1'b0}}, a_neg ? -a : a};
        cnt <= CW'(XLEN - 1);
        if (special) result <= spec_res;
      end else if (state == MD_CALC) begin
        p <= p_step;
        cnt <= cnt - CW'(1);
        if (cnt == '0 && !flush) result <= fin;
      end
    end
  end
  assign done = state == MD_DONE && !flush;
  assign busy = state == MD_CALC;
endmodule
`endif

// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: decodes R/I/branch/RV32M instructions to ALU op codes and sequences M ops
// ports: clk, rst (async, active-high), bus (alu_op_sequencer_if.slave)
// MULDIV_EN: when defined M ops run on muldiv_iter; otherwise they pulse illegal and decode as ADD
module alu_op_sequencer
  import alu_op_sequencer_pkg::*;
#(parameter int IWIDTH = 32, parameter int XLEN = 32, parameter int AWIDTH = 4) (
  input logic clk,
  input logic rst,
  alu_op_sequencer_if.slave bus
);
  logic is_m, accept;
  logic [3:0] code;
  assign is_m = bus.instruction[6:0] == RTYPE && bus.instruction[31:25] == MULDIV;
  assign accept = bus.in_valid && bus.in_ready && !bus.flush;
  assign code = decode_aluop(bus.instruction[31:0]);
`ifdef MULDIV_EN
  muldiv_iter #(.XLEN(XLEN)) u_md (
    .clk(clk), .rst(rst), .start(accept && is_m), .flush(bus.flush), .f3(bus.instruction[14:12]),
    .a(bus.rs1_data), .b(bus.rs2_data), .done(bus.md_valid), .busy(bus.busy), .result(bus.md_result)
  );
  assign bus.in_ready = !bus.busy;
  assign bus.illegal = 1'b0;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.aluop <= AWIDTH'(ALUADD);
      bus.aluop_valid <= 1'b0;
    end else begin
      bus.aluop_valid <= accept && !is_m;
      if (accept && !is_m) bus.aluop <= AWIDTH'(code);
    end
  end
`else
  logic unused_ops;
  assign unused_ops = ^{bus.rs1_data, bus.rs2_data};
  assign bus.in_ready = 1'b1;
  assign bus.md_valid = 1'b0;
  assign bus.md_result = '0;
  assign bus.busy = 1'b0;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.aluop <= AWIDTH'(ALUADD);
      bus.aluop_valid <= 1'b0;
      bus.illegal <= 1'b0;
    end else begin
      bus.aluop_valid <= accept;
      bus.illegal <= accept && is_m;
      if (accept) bus.aluop <= AWIDTH'(is_m ? ALUADD : code);
    end
  end
`endif
endmodule

// File: tb/tb_alu_op_sequencer.sv
// tb_alu_op_sequencer: directed self-checking bench for alu_op_sequencer (XLEN=32)
module tb_alu_op_sequencer;
  import alu_op_sequencer_pkg::*;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int fails = 0;
  alu_op_sequencer_if #(.IWIDTH(32), .XLEN(32), .AWIDTH(4)) bus();
  alu_op_sequencer #(.IWIDTH(32), .XLEN(32), .AWIDTH(4)) dut(.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  localparam logic [31:0] I_SUB  = 32'h402081B3;
  localparam logic [31:0] I_MUL  = 32'h022081B3;
  localparam logic [31:0] I_MULH = 32'h022091B3;
  localparam logic [31:0] I_DIV  = 32'h0220C1B3;
  localparam logic [31:0] I_DIVU = 32'h0220D1B3;
  localparam logic [31:0] I_REM  = 32'h0220E1B3;
  localparam logic [31:0] I_REMU = 32'h0220F1B3;
  task automatic drive(input logic [31:0] ins, input logic [31:0] a, input logic [31:0] b);
    bus.instruction = ins;
    bus.rs1_data = a;
    bus.rs2_data = b;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
  endtask
  task automatic test_reset;
    bus.in_valid = 1'b0;
    bus.flush = 1'b0;
    bus.instruction = '0;
    bus.rs1_data = '0;
    bus.rs2_data = '0;
    @(negedge clk);
    checks++;
    if ({bus.aluop, bus.aluop_valid, bus.illegal} !== {ALUADD, 2'b00}) begin
      fails++;
      $display("FAIL reset_alu got aluop=%0d v=%b ill=%b want 0 0 0", bus.aluop, bus.aluop_valid, bus.illegal);
    end
    checks++;
    if ({bus.md_valid, bus.md_result, bus.busy, bus.in_ready} !== {1'b0, 32'h0, 1'b0, 1'b1}) begin
      fails++;
      $display("FAIL reset_md got mdv=%b res=%h busy=%b rdy=%b want 0 0 0 1", bus.md_valid, bus.md_result, bus.busy, bus.in_ready);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask
  task automatic test_alu_decode;
    logic [31:0] vi [13] = '{32'h402081B3, 32'h4020D1B3, 32'h0020B1B3, 32'h002081B3, 32'h0020C1B3, 32'h0020F1B3,
                             32'h40008193, 32'h4010D193, 32'h0010D193, 32'h0020E063, 32'h00208063, 32'h0020D063, 32'h0000A183};
    logic [3:0] ve [13] = '{ALUSUB, ALUSRA, ALUSLTU, ALUADD, ALUXOR, ALUAND,
                            ALUADD, ALUSRA, ALUSRL, ALUSLTU, ALUSUB, ALUSLT, ALUADD};
    for (int i = 0; i < 13; i++) begin
      @(negedge clk);
      drive(vi[i], 32'h0, 32'h0);
      @(negedge clk);
      checks++;
      if ({bus.aluop_valid, bus.illegal, bus.aluop} !== {2'b10, ve[i]}) begin
        fails++;
        $display("FAIL decode[%0d] %h got v=%b ill=%b aluop=%0d want v=1 ill=0 aluop=%0d", i, vi[i], bus.aluop_valid, bus.illegal, bus.aluop, ve[i]);
      end
      @(negedge clk);
      checks++;
      if ({bus.aluop_valid, bus.aluop} !== {1'b0, ve[i]}) begin
        fails++;
        $display("FAIL pulse[%0d] got v=%b aluop=%0d want v=0 aluop=%0d", i, bus.aluop_valid, bus.aluop, ve[i]);
      end
    end
  endtask
  task automatic test_flush_wins;
    @(negedge clk);
    bus.flush = 1'b1;
    drive(I_SUB, 32'h0, 32'h0);
    bus.flush = 1'b0;
    @(negedge clk);
    checks++;
    if ({bus.aluop_valid, bus.aluop} !== {1'b0, ALUADD}) begin
      fails++;
      $display("FAIL flush_wins got v=%b aluop=%0d want v=0 aluop=0", bus.aluop_valid, bus.aluop);
    end
  endtask
`ifdef MULDIV_EN
  task automatic md_op(input logic [31:0] ins, input logic [31:0] a, input logic [31:0] b,
                       output int lat, output logic [31:0] res, output int bcnt, output int rcnt, output int odd);
    lat = -1;
    res = '0;
    bcnt = 0;
    rcnt = 0;
    odd = 0;
    drive(ins, a, b);
    for (int k = 1; k <= 40 && lat < 0; k++) begin
      @(negedge clk);
      if (bus.busy) bcnt++;
      if (!bus.in_ready) rcnt++;
      if (bus.aluop_valid || bus.illegal) odd++;
      if (bus.md_valid) begin
        lat = k;
        res = bus.md_result;
      end
    end
  endtask
  task automatic test_mulh_back_to_back;
    int lat, bcnt, rcnt, odd;
    logic [31:0] res;
    @(negedge clk);
    md_op(I_MULH, 32'hFFFFFFFE, 32'h00000003, lat, res, bcnt, rcnt, odd);
    checks++;
    if (lat !== 33 || res !== 32'hFFFFFFFF) begin
      fails++;
      $display("FAIL mulh got lat=%0d res=%h want lat=33 res=ffffffff", lat, res);
    end
    checks++;
    if (bcnt !== 32 || rcnt !== 32 || odd !== 0) begin
      fails++;
      $display("FAIL mulh_flags got busy=%0d notready=%0d alu_or_illegal=%0d want 32 32 0", bcnt, rcnt, odd);
    end
    md_op(I_MUL, 32'd6, 32'd7, lat, res, bcnt, rcnt, odd);
    checks++;
    if (lat !== 33 || res !== 32'd42) begin
      fails++;
      $display("FAIL b2b_mul got lat=%0d res=%h want lat=33 res=2a", lat, res);
    end
  endtask
  task automatic test_special;
    int lat, bcnt, rcnt, odd;
    logic [31:0] res;
    @(negedge clk);
    md_op(I_DIV, 32'h80000000, 32'hFFFFFFFF, lat, res, bcnt, rcnt, odd);
    checks++;
    if (lat !== 1 || res !== 32'h80000000 || bcnt !== 0) begin
      fails++;
      $display("FAIL div_ovf got lat=%0d res=%h busy=%0d want 1 80000000 0", lat, res, bcnt);
    end
    @(negedge clk);
    md_op(I_REMU, 32'h00001234, 32'h0, lat, res, bcnt, rcnt, odd);
    checks++;
    if (lat !== 1 || res !== 32'h00001234) begin
      fails++;
      $display("FAIL remu_div0 got lat=%0d res=%h want 1 1234", lat, res);
    end
    @(negedge clk);
    md_op(I_DIV, 32'h00000055, 32'h0, lat, res, bcnt, rcnt, odd);
    checks++;
    if (lat !== 1 || res !== 32'hFFFFFFFF) begin
      fails++;
      $display("FAIL div_div0 got lat=%0d res=%h want 1 ffffffff", lat, res);
    end
  endtask
  task automatic test_flush;
    int lat, bcnt, rcnt, odd, seen;
    logic [31:0] res;
    @(negedge clk);
    drive(I_DIVU, 32'd100, 32'd7);
    repeat (10) @(negedge clk);
    bus.flush = 1'b1;
    @(posedge clk);
    #1 bus.flush = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.busy !== 1'b0 || bus.in_ready !== 1'b1) begin
      fails++;
      $display("FAIL flush_calc got busy=%b rdy=%b want 0 1", bus.busy, bus.in_ready);
    end
    seen = 0;
    repeat (40) @(negedge clk) if (bus.md_valid) seen++;
    checks++;
    if (seen !== 0) begin
      fails++;
      $display("FAIL flush_no_result got md_valid count=%0d want 0", seen);
    end
    md_op(I_REM, 32'hFFFFFFF9, 32'd2, lat, res, bcnt, rcnt, odd);
    checks++;
    if (lat !== 33 || res !== 32'hFFFFFFFF) begin
      fails++;
      $display("FAIL rem_after_flush got lat=%0d res=%h want 33 ffffffff", lat, res);
    end
    @(negedge clk);
    drive(I_DIVU, 32'd5, 32'd0);
    bus.flush = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.md_valid !== 1'b0) begin
      fails++;
      $display("FAIL flush_done got md_valid=%b want 0", bus.md_valid);
    end
    @(posedge clk);
    #1 bus.flush = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.md_valid !== 1'b0 || bus.busy !== 1'b0) begin
      fails++;
      $display("FAIL flush_done_after got md_valid=%b busy=%b want 0 0", bus.md_valid, bus.busy);
    end
  endtask
  task automatic test_rst_mid_calc;
    @(negedge clk);
    drive(I_MUL, 32'd6, 32'd7);
    repeat (5) @(negedge clk);
    checks++;
    if (bus.busy !== 1'b1) begin
      fails++;
      $display("FAIL mid_calc_busy got %b want 1", bus.busy);
    end
    #1 rst = 1'b1;
    #1;
    checks++;
    if ({bus.busy, bus.in_ready, bus.md_valid, bus.md_result} !== {3'b010, 32'h0}) begin
      fails++;
      $display("FAIL rst_mid_calc got busy=%b rdy=%b mdv=%b res=%h want 0 1 0 0", bus.busy, bus.in_ready, bus.md_valid, bus.md_result);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask
`else
  task automatic test_illegal;
    logic [31:0] vi [2] = '{I_MUL, I_DIV};
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      drive(I_SUB, 32'h0, 32'h0);
      @(negedge clk);
      drive(vi[i], 32'd6, 32'd7);
      @(negedge clk);
      checks++;
      if ({bus.illegal, bus.aluop_valid, bus.aluop} !== {2'b11, ALUADD}) begin
        fails++;
        $display("FAIL illegal[%0d] got ill=%b v=%b aluop=%0d want 1 1 0", i, bus.illegal, bus.aluop_valid, bus.aluop);
      end
      checks++;
      if ({bus.md_valid, bus.busy, bus.in_ready, bus.md_result} !== {3'b001, 32'h0}) begin
        fails++;
        $display("FAIL tied_off[%0d] got mdv=%b busy=%b rdy=%b res=%h want 0 0 1 0", i, bus.md_valid, bus.busy, bus.in_ready, bus.md_result);
      end
      @(negedge clk);
      checks++;
      if (bus.illegal !== 1'b0) begin
        fails++;
        $display("FAIL illegal_pulse[%0d] got %b want 0", i, bus.illegal);
      end
    end
  endtask
`endif
  initial begin
    #2000000;
    $display("FAIL timeout after %0d assertions", checks);
    $fatal(1, "timeout");
  end
  initial begin
    test_reset();
    test_alu_decode();
    test_flush_wins();
`ifdef MULDIV_EN
    test_mulh_back_to_back();
    test_special();
    test_flush();
    test_rst_mid_calc();
`else
    test_illegal();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule

// File: doc/alu_op_sequencer.md
Name: alu_op_sequencer

Overview:
- Parametrised successor to the combinational ALU-op decoder.
- Decodes R-type, I-type ALU, branch-compare and RV32M instructions into ALU operation codes.
- Executes M-extension ops on an internal iterative multiply/divide engine, with a valid/ready handshake.
- Sits between the decode stage and the ALU/execute stage; stalls issue while a multi-cycle op is in flight.

Parameters:
- IWIDTH, 32, instruction width.
- XLEN, 32, operand/result width (8..64, even).
- AWIDTH, 4, ALU op code width; codes are the shared ALU constants.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous reset, active-high.
- in_valid  in  1  instruction offered.
- in_ready  out  1  block can accept this cycle.
- instruction  in  IWIDTH  instruction word.
- rs1_data  in  XLEN  operand A (M ops only).
- rs2_data  in  XLEN  operand B (M ops only).
- flush  in  1  abort in-flight M op.
- aluop  out  AWIDTH  registered ALU op code.
- aluop_valid  out  1  one-cycle pulse; aluop is meaningful.
- md_valid  out  1  one-cycle pulse; md_result is meaningful.
- md_result  out  XLEN  multiply/divide result.
- busy  out  1  M op in flight (state CALC).
- illegal  out  1  one-cycle pulse; unsupported M op accepted.

Behaviour:
- Reset (async, rst=1) values:
  - state=IDLE.
  - aluop=ALUADD.
  - aluop_valid=0, md_valid=0, md_result=0, illegal=0, busy=0.
  - in_ready=1.
- Accept: handshake completes when in_valid && in_ready at a rising clk edge.

Decode (opcode = instruction[6:0], f3 = [14:12], bit30, f7 = [31:25]):
- 0110011 with f7 != 0000001:
  - f3 000: SUB if bit30 else ADD.
  - f3 100: XOR. f3 110: OR. f3 111: AND.
  - f3 001: SLL.
  - f3 101: SRA if bit30 else SRL.
  - f3 010: SLT. f3 011: SLTU.
- 0010011: same mapping, except f3 000 is always ADD (bit30 ignored); SRAI/SRLI selected by bit30.
- 1100011:
  - BEQ/BNE → SUB.
  - BLT/BGE → SLT.
  - BLTU/BGEU → SLTU.
- All other opcodes → ADD.

Single-cycle (non-M) path:
- aluop registered; aluop_valid=1 in the cycle after accept; latency 1.

M op path (0110011, f7=0000001):
- aluop is not updated; aluop_valid stays 0.
- Operands latched at accept.

FSM states:
- IDLE:
  - in_ready=1.
  - Accepting an M op moves to CALC; a special case moves to DONE.
- CALC:
  - in_ready=0, busy=1.
  - Runs XLEN iterations, one per cycle: shift-add multiply or restoring divide, on operand magnitudes.
  - Counter goes from XLEN-1 down to 0; at 0, move to DONE.
- DONE:
  - md_valid=1 for one cycle, result applied, in_ready=1.
  - Next state is IDLE, or CALC/DONE if a new M op is accepted this cycle (back-to-back allowed).

Latency:
- Normal M op: md_valid asserts XLEN+1 cycles after the accept edge.
- Special case: md_valid asserts 1 cycle after the accept edge.

Signed arithmetic:
- Operate on magnitudes; negate the 2*XLEN product or the quotient/remainder at the end.
- MUL: low XLEN bits. MULH: s×s high. MULHSU: s×u high. MULHU: u×u high.
- DIV/DIVU: quotient. REM/REMU: remainder; remainder sign follows the dividend.

Special cases (resolved without entering CALC):
- Divide by zero: quotient = all ones; remainder = dividend.
- Signed overflow (most-negative ÷ -1): quotient = most-negative; remainder = 0.

Flush:
- Asserting flush in CALC or DONE returns to IDLE next cycle.
- md_valid is suppressed; no result is delivered.
- flush in IDLE: no effect.
- flush and in_valid in the same cycle: flush wins; nothing is accepted.

Other boundaries:
- in_valid while in CALC is ignored; upstream must hold the instruction.
- rst mid-CALC aborts immediately to reset values.

Optional Feature:
- Macro: MULDIV_EN.
- Defined: M path, FSM and engine are as above.
- Undefined:
  - No FSM or engine is synthesised.
  - Accepting an M op pulses illegal next cycle, with aluop=ALUADD and aluop_valid=1.
  - md_valid, md_result and busy are tied to 0; in_ready is tied to 1.
  - Latency is 1 for all instructions.
- illegal is never asserted when MULDIV_EN is defined.

Decomposition:
- Shared package/defines (extend existing):
  - ALU op codes (ALUADD..ALUSLTU).
  - Opcode constants: RTYPE, ITYPE_ALU, BRANCH.
  - f3 constants, including M-op f3 (MUL..REMU).
  - f7 MULDIV = 0000001.
  - FSM state encodings.
- Sub-module muldiv_iter:
  - Iterative engine with start/flush inputs and done/result outputs, parametrised by XLEN.
  - Contains the counter, magnitude/sign logic and special cases.
  - The top holds decode and handshake.

Test Plan (XLEN=32):
- R-type sweep: SUB x3,x1,x2 (0x402081B3) → aluop=ALUSUB one cycle later, aluop_valid pulse. SRA (0x4020D1B3) → ALUSRA. SLTU → ALUSLTU.
- I-type and branch: ADDI with bit30=1 → ALUADD. SRAI → ALUSRA. BLTU → ALUSLTU. LW → ALUADD.
- MULH rs1=0xFFFFFFFE (-2), rs2=0x00000003 → md_result=0xFFFFFFFF after exactly 33 cycles; busy high 32 cycles; in_ready low throughout.
- DIV rs1=0x80000000, rs2=0xFFFFFFFF → md_result=0x80000000 one cycle after accept. REMU rs2=0, rs1=0x1234 → md_result=0x1234, one cycle.
- DIVU 100/7 accepted; flush asserted at cycle 10 → no md_valid; state IDLE. A following REM -7/2 → md_result=0xFFFFFFFF after 33 cycles.
- Back-to-back: MUL 6×7 accepted in the DONE cycle of the previous op → md_result=42. Build without MULDIV_EN: MUL → illegal pulse, aluop=ALUADD.
